// File: rtl/inpacker_tx_pkg.sv
// Shared definitions for the input packer transmit block.
//   BYTE_W  : width of the packed byte
//   state_t : handshake FSM encoding (idle / offering a byte)
package inpacker_tx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/inpacker_tx_if.sv
// Byte hand-off between the input packer and the UART transmit path.
//   o_byte  : packed, debounced byte (source -> sink)
//   o_valid : o_byte is offered       (source -> sink)
//   i_ready : sink can accept a byte  (sink -> source)
// Modports: master = packer side, slave = transmitter side.
interface inpacker_tx_if;
    import inpacker_tx_pkg::*;

    logic [BYTE_W-1:0] o_byte;
    logic              o_valid;
    logic              i_ready;

    modport master (output o_byte, output o_valid, input i_ready);
    modport slave  (input o_byte, input o_valid, output i_ready);

endinterface

// File: rtl/inpacker_tx_sync_ff2.sv
// Two-flop synchroniser for a bundle of asynchronous single-bit inputs.
// Each bit is synchronised independently; no coherence across bits.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input vector
//   q   : synchronised output vector (two clock edges of latency)
module sync_ff2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inpacker_tx.sv
// Packs eight asynchronous board inputs (i_a = bit 0 ... i_h = bit 7) into
// a byte, synchronises and debounces it, and offers it to the UART transmit
// path over a valid/ready handshake whenever the debounced value differs
// from the last byte that was accepted downstream.
//
// Ports:
//   i_clk      : system clock
//   i_rst      : synchronous active-high reset
//   i_a .. i_h : asynchronous single-bit inputs
//   tx         : inpacker_tx_if.master (o_byte, o_valid out; i_ready in)
//
// Build option:
//   PERIODIC_RESEND_EN : when defined, the current debounced byte is also
//                        re-offered after RESEND_CYCLES idle cycles with no
//                        send. Undefined: sends happen on change only.
module inpacker_tx
    import inpacker_tx_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17,
    parameter int RESEND_CYCLES   = 100000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    input  logic i_e,
    input  logic i_f,
    input  logic i_g,
    input  logic i_h,
    inpacker_tx_if.master tx
);

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("inpacker_tx: DEBOUNCE_CYCLES must be 2 or more");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("inpacker_tx: CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (RESEND_CYCLES < 2) begin : g_bad_resend
        $error("inpacker_tx: RESEND_CYCLES must be 2 or more");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BYTE_W-1:0] raw;
    logic [BYTE_W-1:0] sync;
    logic [BYTE_W-1:0] cand;
    logic [BYTE_W-1:0] stable;
    logic [BYTE_W-1:0] last_sent;
    logic [BYTE_W-1:0] byte_q;
    logic [CNT_W-1:0]  cnt;
    logic              send_go;
    state_t            state;
    state_t            state_next;

    assign raw = {i_h, i_g, i_f, i_e, i_d, i_c, i_b, i_a};

    sync_ff2 #(
        .WIDTH (BYTE_W)
    ) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (raw),
        .q   (sync)
    );

    // Debounce: cand is the previous synchronised sample; cnt counts
    // consecutive cycles where it did not change, saturating at CNT_MAX.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            cand <= sync;
            if (sync != cand) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if ((sync == cand) && (cnt == CNT_MAX)) begin
                stable <= cand;
            end
        end
    end

`ifdef PERIODIC_RESEND_EN
    localparam int               IDLE_W   = $clog2(RESEND_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(RESEND_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts idle cycles without a send; any send (change-triggered or
    // forced) and any cycle in SEND clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idle_cnt <= '0;
        end else if ((state == ST_SEND) || send_go) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        send_go = (stable != last_sent) || (idle_cnt == IDLE_MAX);
    end
`else
    always_comb begin
        send_go = (stable != last_sent);
    end
`endif

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (send_go)    state_next = ST_SEND;
            ST_SEND: if (tx.i_ready) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: valid is exactly "in SEND", so it can only drop through
    // a handshake or a reset.
    always_comb begin
        tx.o_valid = (state == ST_SEND);
        tx.o_byte  = byte_q;
    end

    // Offered byte is captured on entry to SEND and frozen there; last_sent
    // is updated only by an accepted handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_q    <= '0;
            last_sent <= '0;
        end else begin
            if ((state == ST_IDLE) && send_go) begin
                byte_q <= stable;
            end
            if ((state == ST_SEND) && tx.i_ready) begin
                last_sent <= byte_q;
            end
        end
    end

endmodule
